status_transition: RTL and testbench

STATUS_TRANSITION -- requirements
Module: status_transition

---
 rtl/status_transition.sv | 201 ++++++++++++++++++++
 tb/tb_status_transition.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/status_transition.sv
// Elevator status sequencer: tracks pending hall/cabin requests and steps through idle, travel and door phases.
// Optional feature: define DOOR_BTN_EN to honour the door_btn open/close requests.
module status_transition #(
    parameter int MOVE_TICKS  = 4,
    parameter int OPEN_TICKS  = 5,
    parameter int CLOSE_TICKS = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cnt_ck,
    input  logic [7:0] upcall_input,
    input  logic [7:0] downcall_input,
    input  logic [7:0] floor_btn_input,
    input  logic [1:0] door_btn,
    output logic [3:0] sign,
    output logic [2:0] floor,
    output logic [2:0] countdown,
    output logic [7:0] floor_btn
);

    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] MOVE_UP    = 3'd1;
    localparam logic [2:0] MOVE_DOWN  = 3'd2;
    localparam logic [2:0] DOOR_OPEN  = 3'd3;
    localparam logic [2:0] DOOR_CLOSE = 3'd4;

    localparam logic [2:0] MOVE_LOAD  = 3'(MOVE_TICKS - 1);
    localparam logic [2:0] OPEN_LOAD  = 3'(OPEN_TICKS - 1);
    localparam logic [2:0] CLOSE_LOAD = 3'(CLOSE_TICKS - 1);

    logic [2:0] state, state_nxt;
    logic [2:0] floor_nxt, cd_nxt;
    logic [2:0] floor_up, floor_dn;
    logic       dir, dir_nxt;
    logic       tick_prev, tick;
    logic [7:0] up_pend, down_pend, req;
    logic [7:0] clr_btn, clr_up, clr_dn;
    logic       open_req, close_req;

    function automatic logic any_above(input logic [7:0] r, input logic [2:0] f);
        return |(r & (8'hFE << f));
    endfunction

    function automatic logic any_below(input logic [7:0] r, input logic [2:0] f);
        return |(r & ~(8'hFF << f));
    endfunction

    function automatic logic [3:0] sign_of(input logic [2:0] s);
        case (s)
            MOVE_UP:    return 4'b1000;
            MOVE_DOWN:  return 4'b0100;
            DOOR_OPEN:  return 4'b0010;
            DOOR_CLOSE: return 4'b0001;
            default:    return 4'b0000;
        endcase
    endfunction

`ifdef DOOR_BTN_EN
    assign open_req  = door_btn[1];
    assign close_req = door_btn[0];
`else
    logic unused_door_btn;
    assign unused_door_btn = ^door_btn;
    assign open_req  = 1'b0;
    assign close_req = 1'b0;
`endif

    assign tick     = cnt_ck & ~tick_prev;
    assign req      = floor_btn | up_pend | down_pend;
    assign floor_up = (floor == 3'd7) ? floor : floor + 3'd1;
    assign floor_dn = (floor == 3'd0) ? floor : floor - 3'd1;

    always_comb begin
        state_nxt = state;
        floor_nxt = floor;
        dir_nxt   = dir;
        cd_nxt    = countdown;
        case (state)
            IDLE: begin
                if (req[floor] || open_req) begin
                    state_nxt = DOOR_OPEN;
                    cd_nxt    = OPEN_LOAD;
                    // A lone opposite-direction call here is served by turning around, otherwise it would reopen forever.
                    if (req[floor] && !floor_btn[floor]) begin
                        if (dir && !up_pend[floor])
                            dir_nxt = 1'b0;
                        else if (!dir && !down_pend[floor])
                            dir_nxt = 1'b1;
                    end
                end else if (any_above(req, floor) && (dir || !any_below(req, floor))) begin
                    state_nxt = MOVE_UP;
                    dir_nxt   = 1'b1;
                    cd_nxt    = MOVE_LOAD;
                end else if (any_below(req, floor)) begin
                    state_nxt = MOVE_DOWN;
                    dir_nxt   = 1'b0;
                    cd_nxt    = MOVE_LOAD;
                end
            end
            MOVE_UP: begin
                if (tick) begin
                    if (countdown != 3'd0) begin
                        cd_nxt = countdown - 3'd1;
                    end else begin
                        floor_nxt = floor_up;
                        cd_nxt    = MOVE_LOAD;
                        if (floor_btn[floor_up] || up_pend[floor_up] || !any_above(req, floor_up)) begin
                            state_nxt = DOOR_OPEN;
                            cd_nxt    = OPEN_LOAD;
                        end
                    end
                end
            end
            MOVE_DOWN: begin
                if (tick) begin
                    if (countdown != 3'd0) begin
                        cd_nxt = countdown - 3'd1;
                    end else begin
                        floor_nxt = floor_dn;
                        cd_nxt    = MOVE_LOAD;
                        if (floor_btn[floor_dn] || down_pend[floor_dn] || !any_below(req, floor_dn)) begin
                            state_nxt = DOOR_OPEN;
                            cd_nxt    = OPEN_LOAD;
                        end
                    end
                end
            end
            DOOR_OPEN: begin
                if (open_req) begin
                    cd_nxt = OPEN_LOAD;
                end else if (tick && (countdown == 3'd0 || close_req)) begin
                    state_nxt = DOOR_CLOSE;
                    cd_nxt    = CLOSE_LOAD;
                end else if (close_req) begin
                    cd_nxt = 3'd0;
                end else if (tick) begin
                    cd_nxt = countdown - 3'd1;
                end
            end
            DOOR_CLOSE: begin
                if (open_req) begin
                    state_nxt = DOOR_OPEN;
                    cd_nxt    = OPEN_LOAD;
                end else if (tick) begin
                    if (countdown != 3'd0)
                        cd_nxt = countdown - 3'd1;
                    else
                        state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cd_nxt    = 3'd0;
            end
        endcase
    end

    // Requests at the open-door floor are dropped on entry and for as long as the doors stay open.
    always_comb begin
        clr_btn = 8'h00;
        clr_up  = 8'h00;
        clr_dn  = 8'h00;
        if (state_nxt == DOOR_OPEN) begin
            clr_btn[floor_nxt] = 1'b1;
            if (dir_nxt) begin
                clr_up[floor_nxt] = 1'b1;
                if (!any_above(req, floor_nxt))
                    clr_dn[floor_nxt] = 1'b1;
            end else begin
                clr_dn[floor_nxt] = 1'b1;
                if (!any_below(req, floor_nxt))
                    clr_up[floor_nxt] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            floor     <= 3'd0;
            dir       <= 1'b1;
            countdown <= 3'd0;
            sign      <= 4'b0000;
            tick_prev <= 1'b0;
            floor_btn <= 8'h00;
            up_pend   <= 8'h00;
            down_pend <= 8'h00;
        end else begin
            state     <= state_nxt;
            floor     <= floor_nxt;
            dir       <= dir_nxt;
            countdown <= cd_nxt;
            sign      <= sign_of(state_nxt);
            tick_prev <= cnt_ck;
            floor_btn <= (floor_btn | floor_btn_input) & ~clr_btn;
            up_pend   <= (up_pend | (upcall_input & 8'h7F)) & ~clr_up;
            down_pend <= (down_pend | (downcall_input & 8'hFE)) & ~clr_dn;
        end
    end

endmodule

// File: tb/tb_status_transition.sv
// Directed testbench for status_transition: express trip, hall-call stops, mid-move reset and door buttons.
module tb_status_transition;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cnt_ck = 1'b0;
    logic [7:0] upcall_input = 8'h00;
    logic [7:0] downcall_input = 8'h00;
    logic [7:0] floor_btn_input = 8'h00;
    logic [1:0] door_btn = 2'b00;
    logic [3:0] sign;
    logic [2:0] floor;
    logic [2:0] countdown;
    logic [7:0] floor_btn;

    int n_checks = 0;
    int n_fail = 0;

    status_transition dut (
        .clk(clk), .rst(rst), .cnt_ck(cnt_ck),
        .upcall_input(upcall_input), .downcall_input(downcall_input),
        .floor_btn_input(floor_btn_input), .door_btn(door_btn),
        .sign(sign), .floor(floor), .countdown(countdown), .floor_btn(floor_btn)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic wait_clk(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // One tick is a rising cnt_ck seen at a single clk edge; the task returns at a negedge.
    task automatic run_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) cnt_ck = 1'b1;
            @(negedge clk) cnt_ck = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic pulse(input logic [7:0] up, input logic [7:0] dn, input logic [7:0] fb);
        @(negedge clk);
        upcall_input = up;
        downcall_input = dn;
        floor_btn_input = fb;
        @(negedge clk);
        upcall_input = 8'h00;
        downcall_input = 8'h00;
        floor_btn_input = 8'h00;
    endtask

    task automatic test_reset;
        wait_clk(2);
        n_checks++; if (sign !== 4'b0000) begin n_fail++; $display("[TB] FAIL rst_sign got %b want 0000", sign); end
        n_checks++; if (floor !== 3'd0) begin n_fail++; $display("[TB] FAIL rst_floor got %0d want 0", floor); end
        n_checks++; if (countdown !== 3'd0) begin n_fail++; $display("[TB] FAIL rst_countdown got %0d want 0", countdown); end
        rst = 1'b1;
        run_ticks(20);
        n_checks++; if (sign !== 4'b0000) begin n_fail++; $display("[TB] FAIL idle_sign got %b want 0000", sign); end
        n_checks++; if (floor !== 3'd0) begin n_fail++; $display("[TB] FAIL idle_floor got %0d want 0", floor); end
        n_checks++; if (countdown !== 3'd0) begin n_fail++; $display("[TB] FAIL idle_countdown got %0d want 0", countdown); end
        n_checks++; if (floor_btn !== 8'h00) begin n_fail++; $display("[TB] FAIL idle_floor_btn got %b want 00000000", floor_btn); end
    endtask

    task automatic test_express_up;
        pulse(8'h00, 8'h00, 8'h80);
        n_checks++; if (floor_btn !== 8'h80) begin n_fail++; $display("[TB] FAIL express_latch got %b want 10000000", floor_btn); end
        wait_clk(1);
        n_checks++; if (sign !== 4'b1000) begin n_fail++; $display("[TB] FAIL express_start got %b want 1000", sign); end
        n_checks++; if (countdown !== 3'd3) begin n_fail++; $display("[TB] FAIL express_load got %0d want 3", countdown); end
        run_ticks(1);
        n_checks++; if (countdown !== 3'd2) begin n_fail++; $display("[TB] FAIL express_dec got %0d want 2", countdown); end
        run_ticks(3);
        for (int k = 1; k < 7; k++) begin
            n_checks++;
            if (floor !== 3'(k) || sign !== 4'b1000) begin
                n_fail++;
                $display("[TB] FAIL express_step floor %0d sign %b want floor %0d sign 1000", floor, sign, k);
            end
            run_ticks(4);
        end
        n_checks++; if (floor !== 3'd7 || sign !== 4'b0010) begin n_fail++; $display("[TB] FAIL express_arrive floor %0d sign %b want 7 0010", floor, sign); end
        n_checks++; if (floor_btn !== 8'h00) begin n_fail++; $display("[TB] FAIL express_clear got %b want 00000000", floor_btn); end
        n_checks++; if (countdown !== 3'd4) begin n_fail++; $display("[TB] FAIL express_open_load got %0d want 4", countdown); end
        run_ticks(5);
        n_checks++; if (sign !== 4'b0001) begin n_fail++; $display("[TB] FAIL express_close got %b want 0001", sign); end
        run_ticks(2);
        n_checks++; if (sign !== 4'b0000) begin n_fail++; $display("[TB] FAIL express_idle got %b want 0000", sign); end
    endtask

    task automatic test_down_calls;
        pulse(8'h04, 8'h10, 8'h00);
        wait_clk(1);
        n_checks++; if (sign !== 4'b0100) begin n_fail++; $display("[TB] FAIL down_start got %b want 0100", sign); end
        run_ticks(12);
        n_checks++; if (floor !== 3'd4 || sign !== 4'b0010) begin n_fail++; $display("[TB] FAIL down_stop4 floor %0d sign %b want 4 0010", floor, sign); end
        run_ticks(7);
        n_checks++; if (floor !== 3'd4 || sign !== 4'b0100) begin n_fail++; $display("[TB] FAIL down_resume floor %0d sign %b want 4 0100", floor, sign); end
        run_ticks(8);
        n_checks++; if (floor !== 3'd2 || sign !== 4'b0010) begin n_fail++; $display("[TB] FAIL down_stop2 floor %0d sign %b want 2 0010", floor, sign); end
        run_ticks(10);
        n_checks++; if (floor !== 3'd2 || sign !== 4'b0000) begin n_fail++; $display("[TB] FAIL down_idle floor %0d sign %b want 2 0000", floor, sign); end
    endtask

    task automatic test_reset_mid_move;
        pulse(8'h00, 8'h00, 8'h40);
        wait_clk(1);
        n_checks++; if (sign !== 4'b1000) begin n_fail++; $display("[TB] FAIL mid_start got %b want 1000", sign); end
        run_ticks(5);
        n_checks++; if (floor !== 3'd3) begin n_fail++; $display("[TB] FAIL mid_floor got %0d want 3", floor); end
        @(negedge clk) rst = 1'b0;
        #1;
        n_checks++;
        if (sign !== 4'b0000 || floor !== 3'd0 || countdown !== 3'd0 || floor_btn !== 8'h00) begin
            n_fail++;
            $display("[TB] FAIL mid_async sign %b floor %0d cd %0d btn %b want 0000 0 0 00000000", sign, floor, countdown, floor_btn);
        end
        wait_clk(2);
        rst = 1'b1;
        run_ticks(5);
        n_checks++;
        if (sign !== 4'b0000 || floor !== 3'd0 || floor_btn !== 8'h00) begin
            n_fail++;
            $display("[TB] FAIL mid_after sign %b floor %0d btn %b want 0000 0 00000000", sign, floor, floor_btn);
        end
    endtask

    task automatic test_up_call_stop;
        pulse(8'h08, 8'h00, 8'h20);
        n_checks++; if (floor_btn !== 8'h20) begin n_fail++; $display("[TB] FAIL upcall_latch got %b want 00100000", floor_btn); end
        wait_clk(1);
        n_checks++; if (sign !== 4'b1000) begin n_fail++; $display("[TB] FAIL upcall_start got %b want 1000", sign); end
        run_ticks(12);
        n_checks++; if (floor !== 3'd3 || sign !== 4'b0010) begin n_fail++; $display("[TB] FAIL upcall_stop3 floor %0d sign %b want 3 0010", floor, sign); end
        n_checks++; if (floor_btn !== 8'h20) begin n_fail++; $display("[TB] FAIL upcall_keep got %b want 00100000", floor_btn); end
        run_ticks(7);
        n_checks++; if (floor !== 3'd3 || sign !== 4'b1000) begin n_fail++; $display("[TB] FAIL upcall_resume floor %0d sign %b want 3 1000", floor, sign); end
        run_ticks(8);
        n_checks++; if (floor !== 3'd5 || sign !== 4'b0010) begin n_fail++; $display("[TB] FAIL upcall_stop5 floor %0d sign %b want 5 0010", floor, sign); end
        run_ticks(7);
        n_checks++;
        if (floor !== 3'd5 || sign !== 4'b0000 || floor_btn !== 8'h00) begin
            n_fail++;
            $display("[TB] FAIL upcall_idle floor %0d sign %b btn %b want 5 0000 00000000", floor, sign, floor_btn);
        end
    endtask

    task automatic test_door_buttons;
        logic [3:0] hold_sign;
        logic [3:0] close_sign;
        logic [2:0] close_cd;
`ifdef DOOR_BTN_EN
        hold_sign = 4'b0010;
        close_sign = 4'b0001;
        close_cd = 3'd1;
`else
        hold_sign = 4'b0000;
        close_sign = 4'b0010;
        close_cd = 3'd3;
`endif
        pulse(8'h00, 8'h00, 8'h20);
        wait_clk(1);
        n_checks++; if (sign !== 4'b0010 || floor_btn !== 8'h00) begin n_fail++; $display("[TB] FAIL door_open sign %b btn %b want 0010 00000000", sign, floor_btn); end
        door_btn = 2'b10;
        run_ticks(10);
        n_checks++; if (sign !== hold_sign) begin n_fail++; $display("[TB] FAIL door_hold got %b want %b", sign, hold_sign); end
        door_btn = 2'b00;
        run_ticks(7);
        n_checks++; if (sign !== 4'b0000) begin n_fail++; $display("[TB] FAIL door_hold_idle got %b want 0000", sign); end
        pulse(8'h00, 8'h00, 8'h20);
        wait_clk(1);
        n_checks++; if (sign !== 4'b0010) begin n_fail++; $display("[TB] FAIL door_reopen got %b want 0010", sign); end
        door_btn = 2'b01;
        wait_clk(1);
        run_ticks(1);
        n_checks++;
        if (sign !== close_sign || countdown !== close_cd) begin
            n_fail++;
            $display("[TB] FAIL door_close sign %b cd %0d want %b %0d", sign, countdown, close_sign, close_cd);
        end
        door_btn = 2'b00;
        run_ticks(7);
        n_checks++; if (sign !== 4'b0000) begin n_fail++; $display("[TB] FAIL door_close_idle got %b want 0000", sign); end
    endtask

    initial begin
        test_reset;
        test_express_up;
        test_down_calls;
        test_reset_mid_move;
        test_up_call_stop;
        test_door_buttons;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
